// File: rtl/instr_fetch_unit.sv
// Instruction fetch initiator: owns the PC, reads instruction memory every cycle,
// and buffers {pc, instr} pairs in a small prefetch FIFO for the decode stage.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o,
    input  logic        ready_i
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [31:0]   pc_q;
    logic [31:0]   pc_buf    [DEPTH];
    logic [31:0]   instr_buf [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    assign imem_addr  = pc_q;
    assign valid_o    = (count != '0);
    assign instr_o    = instr_buf[rd_ptr];
    assign pc_o       = pc_buf[rd_ptr];
    assign pc_plus4_o = pc_o + 32'd4;

    // A full FIFO still accepts a new word when the head leaves in the same cycle.
    always_comb begin
        pop  = valid_o & ready_i;
        push = ~redirect_valid & ((count < FULL) | pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q   <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_buf[i]    <= '0;
                instr_buf[i] <= '0;
            end
        end else if (redirect_valid) begin
            pc_q   <= {redirect_pc[31:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc_buf[wr_ptr]    <= pc_q;
                instr_buf[wr_ptr] <= imem_rdata;
                wr_ptr            <= wr_ptr + AW'(1);
                pc_q              <= pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, async reset,
// PC wrap on a second instance, and random traffic against a queue-based model.
module tb_instr_fetch_unit;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        valid_o;
    logic        ready_i = 1'b0;

    logic        w_rst = 1'b0;
    logic [31:0] w_addr;
    logic [31:0] w_rdata;
    logic        w_rv = 1'b0;
    logic [31:0] w_rpc = '0;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic [31:0] w_pc4;
    logic        w_valid;
    logic        w_rdy = 1'b1;

    logic [31:0] mem [256];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr[9:2]];
    assign w_rdata    = mem[w_addr[9:2]];

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_o(instr_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
        .valid_o(valid_o), .ready_i(ready_i)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_w (
        .clk(clk), .rst(w_rst), .imem_addr(w_addr), .imem_rdata(w_rdata),
        .redirect_valid(w_rv), .redirect_pc(w_rpc),
        .instr_o(w_instr), .pc_o(w_pc), .pc_plus4_o(w_pc4),
        .valid_o(w_valid), .ready_i(w_rdy)
    );

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        exp_valid;
        logic        chk_data;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(logic rv, logic [31:0] rpc, logic rdy, logic ev,
                                logic cd, logic [31:0] epc, logic [31:0] ein,
                                logic [31:0] ead);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.exp_valid = ev; v.chk_data = cd;
        v.exp_pc = epc; v.exp_instr = ein; v.exp_addr = ead;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a queue of PCs, the fetcher a single next-PC value.
    logic [31:0] q [$];
    logic [31:0] fetch_pc;

    task automatic model_check();
        chk("rnd_valid", {31'b0, valid_o}, {31'b0, q.size() != 0});
        chk("rnd_addr", imem_addr, fetch_pc);
        if (q.size() != 0) begin
            chk("rnd_pc", pc_o, q[0]);
            chk("rnd_instr", instr_o, mem[q[0][9:2]]);
            chk("rnd_pc4", pc_plus4_o, q[0] + 32'd4);
        end
    endtask

    task automatic model_step(input logic rv, input logic [31:0] rpc, input logic rdy);
        if (rv) begin
            q.delete();
            fetch_pc = {rpc[31:2], 2'b00};
        end else begin
            if (q.size() != 0 && rdy) void'(q.pop_front());
            if (q.size() < DEPTH) begin
                q.push_back(fetch_pc);
                fetch_pc = fetch_pc + 32'd4;
            end
        end
    endtask

    initial begin
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h00A0_0113;
        mem[2] = 32'h0020_81B3;
        mem[3] = 32'h0031_A023;
        for (int i = 4; i < 256; i++) mem[i] = 32'h1357_0000 | 32'(i);

        vecs[0]  = mk(0, 32'h0,   1, 0, 1, 32'h0,   32'h0,         32'h0);
        vecs[1]  = mk(0, 32'h0,   1, 1, 1, 32'h0,   32'h0050_0093, 32'h4);
        vecs[2]  = mk(0, 32'h0,   0, 1, 1, 32'h4,   32'h00A0_0113, 32'h8);
        vecs[3]  = mk(0, 32'h0,   0, 1, 1, 32'h4,   32'h00A0_0113, 32'hC);
        vecs[4]  = mk(0, 32'h0,   0, 1, 1, 32'h4,   32'h00A0_0113, 32'hC);
        vecs[5]  = mk(0, 32'h0,   1, 1, 1, 32'h4,   32'h00A0_0113, 32'hC);
        vecs[6]  = mk(0, 32'h0,   1, 1, 1, 32'h8,   32'h0020_81B3, 32'h10);
        vecs[7]  = mk(0, 32'h0,   0, 1, 1, 32'hC,   32'h0031_A023, 32'h14);
        vecs[8]  = mk(1, 32'h43,  0, 1, 1, 32'hC,   32'h0031_A023, 32'h14);
        vecs[9]  = mk(0, 32'h0,   1, 0, 0, 32'h0,   32'h0,         32'h40);
        vecs[10] = mk(0, 32'h0,   1, 1, 1, 32'h40,  32'h1357_0010, 32'h44);
        vecs[11] = mk(1, 32'h102, 1, 1, 1, 32'h44,  32'h1357_0011, 32'h48);
        vecs[12] = mk(0, 32'h0,   1, 0, 0, 32'h0,   32'h0,         32'h100);
        vecs[13] = mk(0, 32'h0,   1, 1, 1, 32'h100, 32'h1357_0040, 32'h104);

        #1;
        chk("reset_valid", {31'b0, valid_o}, 32'h0);
        chk("reset_addr", imem_addr, 32'h0);
        chk("reset_pc", pc_o, 32'h0);
        chk("reset_instr", instr_o, 32'h0);

        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 14; i++) begin
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            ready_i        = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d_valid", i), {31'b0, valid_o}, {31'b0, vecs[i].exp_valid});
            chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
            if (vecs[i].chk_data) begin
                chk($sformatf("vec%0d_pc", i), pc_o, vecs[i].exp_pc);
                chk($sformatf("vec%0d_instr", i), instr_o, vecs[i].exp_instr);
                chk($sformatf("vec%0d_pc4", i), pc_plus4_o, vecs[i].exp_pc + 32'd4);
            end
            @(negedge clk);
        end

        // Asynchronous reset asserted between edges while data is buffered.
        redirect_valid = 1'b0;
        ready_i        = 1'b1;
        #1;
        chk("pre_rst_valid", {31'b0, valid_o}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, valid_o}, 32'h0);
        chk("async_rst_addr", imem_addr, 32'h0);
        chk("async_rst_pc", pc_o, 32'h0);
        chk("async_rst_instr", instr_o, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        q.delete();
        fetch_pc = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            logic        rv;
            logic [31:0] rpc;
            logic        rdy;
            rdy = ($urandom_range(0, 9) < 7);
            rv  = ($urandom_range(0, 19) == 0);
            rpc = $urandom;
            redirect_valid = rv;
            redirect_pc    = rpc;
            ready_i        = rdy;
            #1;
            model_check();
            model_step(rv, rpc, rdy);
            @(negedge clk);
        end
        redirect_valid = 1'b0;

        // PC wrap on the instance reset to 0xFFFF_FFF8.
        w_rst = 1'b1;
        #1;
        chk("wrap_c0_valid", {31'b0, w_valid}, 32'h0);
        chk("wrap_c0_addr", w_addr, 32'hFFFF_FFF8);
        @(negedge clk);
        #1;
        chk("wrap_c1_valid", {31'b0, w_valid}, 32'h1);
        chk("wrap_c1_pc", w_pc, 32'hFFFF_FFF8);
        chk("wrap_c1_instr", w_instr, 32'h1357_00FE);
        chk("wrap_c1_pc4", w_pc4, 32'hFFFF_FFFC);
        @(negedge clk);
        #1;
        chk("wrap_c2_pc", w_pc, 32'hFFFF_FFFC);
        chk("wrap_c2_instr", w_instr, 32'h1357_00FF);
        chk("wrap_c2_pc4", w_pc4, 32'h0);
        @(negedge clk);
        #1;
        chk("wrap_c3_pc", w_pc, 32'h0);
        chk("wrap_c3_instr", w_instr, 32'h0050_0093);
        chk("wrap_c3_pc4", w_pc4, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
